arm_pose_sequencer: RTL and testbench
=====================================

# arm_pose_sequencer

Command-driven sequencer for the three-servo pick-and-place arm. It accepts a PICKUP or DROPOFF command from the navigation controller and steps the claw, upper-joint and lower-joint setpoints through a fixed three-pose sequence. It advances only after all three servo position flags have held stable for a programmable number of 20 ms servo frames. It sits between the navigation FSM and the three servo PWM instances, replacing hard-wired pose sequencing with a handshake, settle qualification and a timeout.

## Interface
- FRAME_TICKS, 2000000, clock cycles per servo frame (20 ms at 100 MHz)
- SETTLE_FRAMES, 5, consecutive all-flags-high frames required to advance a step (1..15)
- TIMEOUT_FRAMES, 150, frames allowed per step before fault (1..255)

Ports:
- CLK  in  1  system clock; one clock domain, all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- CMD_VALID  in  1  command request from navigation
- CMD_OP  in  1  0 = PICKUP, 1 = DROPOFF; sampled on accept
- CMD_READY  out  1  high in IDLE only
- CLAW_FLAG, JOINTHIGH_FLAG, JOINTLOW_FLAG  in  1 each  servo at-position flags
- CLAW_DESIRED, JOINTHIGH_DESIRED, JOINTLOW_DESIRED  out  20 each  servo setpoints in 100 MHz counts
- FRAME_TICK  out  1  one-cycle pulse on the last cycle of each frame
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle completion pulse (success or fault)
- ERROR  out  1  last command faulted; held until next accept
- STEP  out  2  current step index 0..2 (0 in IDLE)

## Operation
- States: IDLE, RUN, FAULT.
- Accept occurs when CMD_VALID & CMD_READY. In the next cycle: RUN, STEP=0, BUSY=1, ERROR=0, and the step-0 setpoints are driven.
- PICKUP steps:
  - 0: claw open, high pick, low pick
  - 1: claw close, high pick, low pick
  - 2: claw close, high drop, low drop
- DROPOFF steps:
  - 0: claw close, high drop, low drop
  - 1: claw open, high drop, low drop
  - 2: claw open, high drop, low drop (stow/hold)
- Step entry clears settle_cnt and timeout_cnt and drives the new setpoints.
- On each FRAME_TICK in RUN (except a tick in the entry cycle itself):
  - If all three flags are high, settle_cnt increments; otherwise settle_cnt resets to 0.
  - timeout_cnt increments.
- Flags are sampled only on FRAME_TICK. Between ticks, flag glitches are ignored.
- Advance: settle_cnt reaching SETTLE_FRAMES advances STEP on the following cycle. After step 2, the block returns to IDLE, pulses DONE=1 for 1 cycle with ERROR=0, and BUSY falls in the same cycle.
- Timeout: timeout_cnt reaching TIMEOUT_FRAMES with settle incomplete moves the block to FAULT for 1 cycle, then to IDLE with DONE=1 and ERROR=1. Setpoints hold the faulted step's pose.
- Simultaneous settle completion and timeout on the same tick: settle wins (advance).
- Setpoints in IDLE hold the last driven pose; they never revert spontaneously.
- CMD_VALID while BUSY is ignored (CMD_READY=0). Commands are not queued.

## Timing
- Reset values:
  - state IDLE, CMD_READY=1, BUSY=0, DONE=0, ERROR=0, STEP=0
  - frame counter 0, FRAME_TICK=0
  - setpoints = stow pose (CLAW_OPEN, HIGH_DROP, LOW_DROP)
- RST mid-sequence aborts immediately to the reset state. No DONE pulse is issued.
- Frame counter: free-running 0..FRAME_TICKS-1, wrapping to 0. FRAME_TICK=1 when the count equals FRAME_TICKS-1. RST restarts it.
- Latency:
  - accept to first setpoint change: 1 cycle
  - settle qualification to STEP change: 1 cycle
  - final settle to DONE: 1 cycle
- Counter widths: settle_cnt 4 bits, timeout_cnt 8 bits, frame counter 21 bits. Counters saturate and never wrap while in RUN.

## Structure
- Shared package arm_pkg holds:
  - pose constants: CLAW_OPEN=1, CLAW_CLOSE=199218, HIGH_PICK=31248, HIGH_DROP=191394, LOW_PICK=183400, LOW_DROP=113274
  - OP_PICKUP/OP_DROPOFF encodings
  - the state enum
- Pose lookup (op, step) → three setpoints is a combinational function in the package.
- Sub-module settle_qualifier holds settle_cnt and timeout_cnt. Inputs: tick, all_flags, clear. Outputs: settled, timed_out.

## Test plan
All scenarios use FRAME_TICKS=10, SETTLE_FRAMES=2, TIMEOUT_FRAMES=6.

- Reset → CMD_READY=1, setpoints 1/191394/113274, FRAME_TICK every 10 cycles.
- PICKUP, flags held high → STEP sequence 0,1,2. Setpoints go 1/31248/183400, then 199218/31248/183400, then 199218/191394/113274. Single DONE with ERROR=0. Each step lasts 2–3 frames.
- DROPOFF, JOINTLOW_FLAG low from step 1 entry → timeout after 6 ticks. DONE=1 with ERROR=1, claw held at 1. Next accept clears ERROR.
- Flags drop for one tick after one good tick → settle_cnt restarts, so the step takes one extra qualified pair. Flag glitches between ticks leave no effect.
- CMD_VALID pulsed while BUSY → ignored, sequence unchanged. RST asserted mid-step 1 → reset values next cycle, no DONE.
- Settle and timeout complete on the same tick (flags high on ticks 5–6 with SETTLE=2, TIMEOUT=6) → step advances, no fault.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared constants, state encoding and pose lookup for the arm pose sequencer.
package arm_pkg;

  localparam int unsigned POS_W     = 20;
  localparam int unsigned STEP_W    = 2;
  localparam int unsigned SETTLE_W  = 4;
  localparam int unsigned TIMEOUT_W = 8;
  localparam int unsigned FRAME_W   = 21;
  localparam int unsigned LAST_STEP = 2;

  // Servo setpoints in 100 MHz counts
  localparam logic [POS_W-1:0] CLAW_OPEN  = 20'd1;
  localparam logic [POS_W-1:0] CLAW_CLOSE = 20'd199218;
  localparam logic [POS_W-1:0] HIGH_PICK  = 20'd31248;
  localparam logic [POS_W-1:0] HIGH_DROP  = 20'd191394;
  localparam logic [POS_W-1:0] LOW_PICK   = 20'd183400;
  localparam logic [POS_W-1:0] LOW_DROP   = 20'd113274;

  localparam logic OP_PICKUP  = 1'b0;
  localparam logic OP_DROPOFF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [POS_W-1:0] claw;
    logic [POS_W-1:0] high;
    logic [POS_W-1:0] low;
  } pose_t;

  localparam pose_t STOW_POSE = {CLAW_OPEN, HIGH_DROP, LOW_DROP};

  // Map (operation, step) to the three servo setpoints
  function automatic pose_t pose_lookup(input logic op, input logic [STEP_W-1:0] step);
    pose_t p;
    p = STOW_POSE;
    if (op == OP_PICKUP) begin
      case (step)
        2'd0:    p = {CLAW_OPEN,  HIGH_PICK, LOW_PICK};
        2'd1:    p = {CLAW_CLOSE, HIGH_PICK, LOW_PICK};
        2'd2:    p = {CLAW_CLOSE, HIGH_DROP, LOW_DROP};
        default: p = STOW_POSE;
      endcase
    end else begin
      case (step)
        2'd0:    p = {CLAW_CLOSE, HIGH_DROP, LOW_DROP};
        2'd1:    p = {CLAW_OPEN,  HIGH_DROP, LOW_DROP};
        2'd2:    p = {CLAW_OPEN,  HIGH_DROP, LOW_DROP};
        default: p = STOW_POSE;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/settle_qualifier.sv
// Per-step settle and timeout frame counters; both saturate rather than wrap.
module settle_qualifier
  import arm_pkg::*;
#(
  parameter int unsigned SETTLE_FRAMES  = 5,
  parameter int unsigned TIMEOUT_FRAMES = 150
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic all_flags,
  input  logic clear,
  output logic settled,
  output logic timed_out
);

  logic [SETTLE_W-1:0]  settle_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;

  // Count consecutive good frames and total frames spent in the current step
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      settle_cnt  <= '0;
      timeout_cnt <= '0;
    end else if (tick) begin
      if (!all_flags)
        settle_cnt <= '0;
      else if (settle_cnt != '1)
        settle_cnt <= settle_cnt + SETTLE_W'(1);
      if (timeout_cnt != '1)
        timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
    end
  end

  assign settled   = (settle_cnt  >= SETTLE_W'(SETTLE_FRAMES));
  assign timed_out = (timeout_cnt >= TIMEOUT_W'(TIMEOUT_FRAMES));

endmodule

// File: rtl/arm_pose_sequencer.sv
// Command-driven three-pose sequencer for the pick-and-place arm servos.
module arm_pose_sequencer
  import arm_pkg::*;
#(
  parameter int unsigned FRAME_TICKS    = 2000000,
  parameter int unsigned SETTLE_FRAMES  = 5,
  parameter int unsigned TIMEOUT_FRAMES = 150
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  input  logic              CMD_OP,
  output logic              CMD_READY,
  input  logic              CLAW_FLAG,
  input  logic              JOINTHIGH_FLAG,
  input  logic              JOINTLOW_FLAG,
  output logic [POS_W-1:0]  CLAW_DESIRED,
  output logic [POS_W-1:0]  JOINTHIGH_DESIRED,
  output logic [POS_W-1:0]  JOINTLOW_DESIRED,
  output logic              FRAME_TICK,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [STEP_W-1:0] STEP
);

  seq_state_e          state, state_d;
  logic [STEP_W-1:0]   step_d;
  logic                op_q, op_d;
  pose_t               pose_q, pose_d;
  logic                busy_d, done_d, error_d, ready_d;
  logic                step_entry, entry_d;
  logic [FRAME_W-1:0]  frame_cnt, frame_cnt_nxt;
  logic                all_flags, qual_tick, qual_clear, settled, timed_out;

  // Free-running frame counter wrap
  always_comb frame_cnt_nxt = (frame_cnt == FRAME_W'(FRAME_TICKS - 1)) ? '0
                                                                       : frame_cnt + FRAME_W'(1);

  // Frame counter with registered tick on the last cycle of each frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt  <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      frame_cnt  <= frame_cnt_nxt;
      FRAME_TICK <= (frame_cnt_nxt == FRAME_W'(FRAME_TICKS - 1));
    end
  end

  // Ticks landing in a step's entry cycle are not counted
  assign all_flags  = CLAW_FLAG & JOINTHIGH_FLAG & JOINTLOW_FLAG;
  assign qual_tick  = FRAME_TICK & (state == ST_RUN) & ~step_entry;
  assign qual_clear = step_entry | (state != ST_RUN);

  settle_qualifier #(
    .SETTLE_FRAMES  (SETTLE_FRAMES),
    .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
  ) u_qual (
    .CLK       (CLK),
    .RST       (RST),
    .tick      (qual_tick),
    .all_flags (all_flags),
    .clear     (qual_clear),
    .settled   (settled),
    .timed_out (timed_out)
  );

  // State register and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      STEP       <= '0;
      op_q       <= OP_PICKUP;
      pose_q     <= STOW_POSE;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      CMD_READY  <= 1'b1;
      step_entry <= 1'b0;
    end else begin
      state      <= state_d;
      STEP       <= step_d;
      op_q       <= op_d;
      pose_q     <= pose_d;
      BUSY       <= busy_d;
      DONE       <= done_d;
      ERROR      <= error_d;
      CMD_READY  <= ready_d;
      step_entry <= entry_d;
    end
  end

  // Next-state and output decode; settle completion beats timeout
  always_comb begin
    state_d = state;
    step_d  = STEP;
    op_d    = op_q;
    pose_d  = pose_q;
    done_d  = 1'b0;
    error_d = ERROR;
    entry_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          state_d = ST_RUN;
          step_d  = '0;
          op_d    = CMD_OP;
          pose_d  = pose_lookup(CMD_OP, STEP_W'(0));
          error_d = 1'b0;
          entry_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!step_entry) begin
          if (settled) begin
            if (STEP == STEP_W'(LAST_STEP)) begin
              state_d = ST_IDLE;
              step_d  = '0;
              done_d  = 1'b1;
            end else begin
              step_d  = STEP + STEP_W'(1);
              pose_d  = pose_lookup(op_q, step_d);
              entry_d = 1'b1;
            end
          end else if (timed_out) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
        step_d  = '0;
        done_d  = 1'b1;
        error_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  assign CLAW_DESIRED      = pose_q.claw;
  assign JOINTHIGH_DESIRED = pose_q.high;
  assign JOINTLOW_DESIRED  = pose_q.low;

endmodule

// File: tb/tb_arm_pose_sequencer.sv
// Self-checking bench for arm_pose_sequencer with a cycle-level reference model.
module tb_arm_pose_sequencer;

  localparam int FT = 10;
  localparam int SF = 2;
  localparam int TF = 6;

  logic        CLK, RST, CMD_VALID, CMD_OP, CMD_READY;
  logic        CLAW_FLAG, JOINTHIGH_FLAG, JOINTLOW_FLAG;
  logic [19:0] CLAW_DESIRED, JOINTHIGH_DESIRED, JOINTLOW_DESIRED;
  logic        FRAME_TICK, BUSY, DONE, ERROR;
  logic [1:0]  STEP;

  arm_pose_sequencer #(
    .FRAME_TICKS(FT), .SETTLE_FRAMES(SF), .TIMEOUT_FRAMES(TF)
  ) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP), .CMD_READY(CMD_READY),
    .CLAW_FLAG(CLAW_FLAG), .JOINTHIGH_FLAG(JOINTHIGH_FLAG), .JOINTLOW_FLAG(JOINTLOW_FLAG),
    .CLAW_DESIRED(CLAW_DESIRED), .JOINTHIGH_DESIRED(JOINTHIGH_DESIRED),
    .JOINTLOW_DESIRED(JOINTLOW_DESIRED), .FRAME_TICK(FRAME_TICK), .BUSY(BUSY),
    .DONE(DONE), .ERROR(ERROR), .STEP(STEP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 running, 2 faulted
  int m_mode, m_step, m_claw, m_high, m_low, m_settle, m_tout, m_age, m_cyc;
  bit m_op, m_done, m_err;

  bit obs_entry, obs_prev_busy;
  logic [1:0] obs_prev_step;

  typedef struct {
    logic rst, valid, op;
    logic e_ready, e_busy, e_done, e_tick;
    logic [1:0] e_step;
    int e_claw, e_high, e_low;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_pose(input bit op, input int s);
    if (!op) begin
      case (s)
        0: begin m_claw = 1;      m_high = 31248;  m_low = 183400; end
        1: begin m_claw = 199218; m_high = 31248;  m_low = 183400; end
        default: begin m_claw = 199218; m_high = 191394; m_low = 113274; end
      endcase
    end else begin
      case (s)
        0: begin m_claw = 199218; m_high = 191394; m_low = 113274; end
        default: begin m_claw = 1; m_high = 191394; m_low = 113274; end
      endcase
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge
  task automatic model_step(input logic rst, input logic valid, input logic op, input logic allf);
    bit tick_now;
    tick_now = (m_cyc == FT - 1);
    if (rst) begin
      m_mode = 0; m_step = 0; m_done = 0; m_err = 0; m_settle = 0; m_tout = 0; m_age = 0;
      m_claw = 1; m_high = 191394; m_low = 113274; m_cyc = 0;
    end else begin
      m_done = 0;
      case (m_mode)
        0: if (valid) begin
             m_mode = 1; m_step = 0; m_op = op; set_pose(op, 0); m_err = 0;
             m_age = 0; m_settle = 0; m_tout = 0;
           end
        1: begin
             if (m_age > 0 && m_settle >= SF) begin
               if (m_step == 2) begin
                 m_mode = 0; m_step = 0; m_done = 1;
               end else begin
                 m_step++; set_pose(m_op, m_step); m_age = 0; m_settle = 0; m_tout = 0;
               end
             end else if (m_age > 0 && m_tout >= TF) begin
               m_mode = 2;
             end else begin
               if (m_age > 0 && tick_now) begin
                 m_settle = allf ? ((m_settle < 15) ? m_settle + 1 : 15) : 0;
                 m_tout   = (m_tout < 255) ? m_tout + 1 : 255;
               end
               m_age++;
             end
           end
        default: begin m_mode = 0; m_step = 0; m_done = 1; m_err = 1; end
      endcase
      m_cyc = (m_cyc + 1) % FT;
    end
  endtask

  function automatic logic [66:0] dut_vec();
    return {CMD_READY, BUSY, DONE, ERROR, STEP, CLAW_DESIRED, JOINTHIGH_DESIRED,
            JOINTLOW_DESIRED, FRAME_TICK};
  endfunction

  function automatic logic [66:0] model_vec();
    return {m_mode == 0, m_mode != 0, m_done, m_err, 2'(m_step), 20'(m_claw), 20'(m_high),
            20'(m_low), m_cyc == FT - 1};
  endfunction

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge
  task automatic cycle(input logic rst, input logic valid, input logic op, input logic [2:0] f);
    @(negedge CLK);
    RST = rst; CMD_VALID = valid; CMD_OP = op;
    {CLAW_FLAG, JOINTHIGH_FLAG, JOINTLOW_FLAG} = f;
    @(posedge CLK);
    model_step(rst, valid, op, &f);
    #1;
    check("model", 128'(dut_vec()), 128'(model_vec()));
    obs_entry     = BUSY && (!obs_prev_busy || STEP != obs_prev_step);
    obs_prev_busy = BUSY;
    obs_prev_step = STEP;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && !CMD_READY; i++) cycle(1'b0, 1'b0, 1'b0, 3'b111);
    check("wait_idle", 128'(CMD_READY), 128'(1));
  endtask

  function automatic vec_t mk(input logic rst, input logic valid, input logic op,
                              input logic rdy, input logic busy, input logic tick,
                              input int claw, input int high, input int low);
    vec_t v;
    v.rst = rst; v.valid = valid; v.op = op; v.e_ready = rdy; v.e_busy = busy;
    v.e_done = 1'b0; v.e_tick = tick; v.e_step = 2'd0;
    v.e_claw = claw; v.e_high = high; v.e_low = low;
    return v;
  endfunction

  // Accept a PICKUP and shape flags on each counted tick of step 0 from a good/bad mask
  task automatic pattern_step0(input logic [7:0] goodmask, output int qidx);
    logic [2:0] f;
    bit tk;
    qidx = 0;
    cycle(1'b0, 1'b1, 1'b0, 3'b111);
    for (int i = 0; i < 300 && BUSY && STEP == 2'd0 && !DONE; i++) begin
      tk = (m_cyc == FT - 1) && !obs_entry;
      if (tk) begin
        f = ((qidx < 8) && goodmask[qidx[2:0]]) ? 3'b111 : 3'b011;
        qidx++;
      end else begin
        f = 3'($urandom);
      end
      cycle(1'b0, 1'b0, 1'b0, f);
    end
  endtask

  int ticks [3];
  int ent_claw [3];
  int ent_high [3];
  int ent_low [3];
  int exp_claw [3] = '{1, 199218, 199218};
  int exp_high [3] = '{31248, 31248, 191394};
  int exp_low  [3] = '{183400, 183400, 113274};
  bit got_done, err_at_done;
  int claw_at_done, high_at_done, t, q, dcount, first_tick, tcount;
  logic [2:0] rf;
  int thr;

  initial begin
    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 1'b0;
    CLAW_FLAG = 1'b1; JOINTHIGH_FLAG = 1'b1; JOINTLOW_FLAG = 1'b1;
    obs_prev_busy = 1'b0; obs_prev_step = 2'd0; obs_entry = 1'b0;
    m_cyc = 0; m_mode = 0;

    // Reset, frame tick cadence, accept and ignored command while busy
    tbl[0] = mk(1, 0, 0, 1, 0, 0, 1, 191394, 113274);
    for (int i = 1; i <= 10; i++) tbl[i] = mk(0, 0, 0, 1, 0, (i == 9), 1, 191394, 113274);
    tbl[11] = mk(0, 1, 0, 0, 1, 0, 1, 31248, 183400);
    tbl[12] = mk(0, 1, 1, 0, 1, 0, 1, 31248, 183400);
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rst, tbl[i].valid, tbl[i].op, 3'b111);
      check($sformatf("tbl_row%0d", i), 128'(dut_vec()),
            128'({tbl[i].e_ready, tbl[i].e_busy, tbl[i].e_done, 1'b0, tbl[i].e_step,
                  20'(tbl[i].e_claw), 20'(tbl[i].e_high), 20'(tbl[i].e_low), tbl[i].e_tick}));
    end
    wait_idle();

    // PICKUP with flags held high
    for (int s = 0; s < 3; s++) begin ticks[s] = 0; ent_claw[s] = 0; ent_high[s] = 0; ent_low[s] = 0; end
    got_done = 0; err_at_done = 1;
    cycle(1'b0, 1'b1, 1'b0, 3'b111);
    ent_claw[0] = int'(CLAW_DESIRED); ent_high[0] = int'(JOINTHIGH_DESIRED); ent_low[0] = int'(JOINTLOW_DESIRED);
    for (int i = 0; i < 300 && !got_done; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'b111);
      if (obs_entry && STEP < 2'd3) begin
        ent_claw[STEP] = int'(CLAW_DESIRED); ent_high[STEP] = int'(JOINTHIGH_DESIRED);
        ent_low[STEP] = int'(JOINTLOW_DESIRED);
      end
      if (BUSY && FRAME_TICK && !obs_entry && STEP < 2'd3) ticks[STEP]++;
      if (DONE) begin got_done = 1; err_at_done = ERROR; end
    end
    check("s1_done", 128'(got_done), 128'(1));
    check("s1_error", 128'(err_at_done), 128'(0));
    for (int s = 0; s < 3; s++) begin
      check($sformatf("s1_ticks_step%0d", s), 128'(ticks[s]), 128'(SF));
      check($sformatf("s1_pose_step%0d", s), 128'({20'(ent_claw[s]), 20'(ent_high[s]), 20'(ent_low[s])}),
            128'({20'(exp_claw[s]), 20'(exp_high[s]), 20'(exp_low[s])}));
    end
    dcount = 0;
    for (int i = 0; i < 20; i++) begin cycle(1'b0, 1'b0, 1'b0, 3'b111); if (DONE) dcount++; end
    check("s1_single_done", 128'(dcount), 128'(0));
    check("s1_hold_pose", 128'({CLAW_DESIRED, JOINTHIGH_DESIRED, JOINTLOW_DESIRED}),
          128'({20'd199218, 20'd191394, 20'd113274}));

    // DROPOFF with JOINTLOW_FLAG low from step 1 entry
    cycle(1'b0, 1'b1, 1'b1, 3'b111);
    for (int i = 0; i < 100 && !(BUSY && STEP == 2'd1); i++) cycle(1'b0, 1'b0, 1'b0, 3'b111);
    check("s2_reach_step1", 128'(STEP), 128'(1));
    t = 0; got_done = 0; err_at_done = 0; claw_at_done = 0; high_at_done = 0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'b110);
      if (BUSY && STEP == 2'd1 && FRAME_TICK && !obs_entry) t++;
      if (DONE) begin
        got_done = 1; err_at_done = ERROR;
        claw_at_done = int'(CLAW_DESIRED); high_at_done = int'(JOINTHIGH_DESIRED);
      end
    end
    check("s2_done", 128'(got_done), 128'(1));
    check("s2_error", 128'(err_at_done), 128'(1));
    check("s2_timeout_ticks", 128'(t), 128'(TF));
    check("s2_held_pose", 128'({20'(claw_at_done), 20'(high_at_done)}), 128'({20'd1, 20'd191394}));
    cycle(1'b0, 1'b1, 1'b0, 3'b111);
    check("s2_error_cleared", 128'({BUSY, ERROR}), 128'(2'b10));
    wait_idle();

    // Bad tick after one good tick restarts settling; glitches between ticks ignored
    pattern_step0(8'b0000_1101, q);
    check("s3_qual_ticks", 128'(q), 128'(4));
    check("s3_advanced", 128'({BUSY, STEP, ERROR}), 128'({1'b1, 2'd1, 1'b0}));

    // Reset in the middle of step 1
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 3'b111);
    cycle(1'b1, 1'b0, 1'b0, 3'b111);
    check("s5_reset_vals", 128'(dut_vec()),
          128'({1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 20'd1, 20'd191394, 20'd113274, 1'b0}));
    dcount = 0; first_tick = -1; tcount = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'b111);
      if (DONE) dcount++;
      if (FRAME_TICK) begin tcount++; if (first_tick < 0) first_tick = i; end
    end
    check("s5_no_done", 128'(dcount), 128'(0));
    check("s5_tick_pos", 128'({16'(first_tick), 16'(tcount)}), 128'({16'd9, 16'd2}));

    // Settle and timeout complete on the same tick: advance wins
    pattern_step0(8'b0011_0000, q);
    check("s4_qual_ticks", 128'(q), 128'(TF));
    check("s4_advanced", 128'({BUSY, STEP, ERROR, DONE}), 128'({1'b1, 2'd1, 1'b0, 1'b0}));
    wait_idle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      thr = ((i / 500) % 2 == 0) ? 15 : 1;
      rf = {($urandom_range(0, thr) != 0), ($urandom_range(0, thr) != 0), ($urandom_range(0, thr) != 0)};
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
